id_ex_pipe_stage: RTL and testbench

Parametrised pipeline stage register for the ID→EX boundary and any later stage boundary in the five-stage core. It carries a packed payload (instruction word, destination register, operands, extension, PC+4) with a valid/ready handshake instead of a bare stall/flush-to-zero register. An optional two-entry skid buffer breaks the combinational ready path. A saturating back-pressure counter supports hazard-rate profiling. Empty slots present a zero payload, so downstream decoders see `sll $0,$0,0` (nop) and write register 0.

---
 rtl/id_ex_pipe_stage.sv | 111 +++++++++++
 tb/tb_id_ex_pipe_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
// Valid/ready pipeline stage register with an optional two-entry skid buffer.
// Empty slots present an all-zero payload, which downstream decoders see as a nop.
module id_ex_pipe_stage #(
  parameter int DATA_W = 165,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_q,  head_d;
  logic [DATA_W-1:0] skid_q,  skid_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              accept;
  logic              consume;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // With the skid buffer, in_ready depends only on the state register.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    if (SKID != 0) begin
      in_ready = (state_q != ST_TWO);
    end else begin
      in_ready = !out_valid || out_ready;
    end
    accept   = in_valid && in_ready && !flush;
    consume  = out_valid && out_ready && !flush;
    out_data = out_valid ? head_q : '0;
    stall_cnt = cnt_q;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          head_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          head_d = in_data;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (consume) begin
          state_d = ST_EMPTY;
          head_d  = '0;
        end
      end
      ST_TWO: begin
        if (consume) begin
          state_d = ST_ONE;
          head_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        head_d  = '0;
        skid_d  = '0;
      end
    endcase
    // Flush kills every held entry but keeps the profiling counter.
    if (flush) begin
      state_d = ST_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else if (out_valid && !out_ready) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: skid (default width), no-skid and narrow-counter instances.
module tb_id_ex_pipe_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SKID=1, defaults
  logic a_rst = 1'b0, a_fl = 1'b0, a_iv = 1'b0, a_ordy = 1'b0;
  logic a_ir, a_ov;
  logic [164:0] a_id = '0, a_od;
  logic [15:0]  a_cnt;
  // Instance B: SKID=0
  logic b_rst = 1'b0, b_fl = 1'b0, b_iv = 1'b0, b_ordy = 1'b0;
  logic b_ir, b_ov;
  logic [31:0] b_id = '0, b_od;
  logic [15:0] b_cnt;
  // Instance C: SKID=1, CNT_W=3
  logic c_rst = 1'b0, c_fl = 1'b0, c_iv = 1'b0, c_ordy = 1'b0;
  logic c_ir, c_ov;
  logic [7:0] c_id = '0, c_od;
  logic [2:0] c_cnt;

  id_ex_pipe_stage u_a (
    .clk(clk), .reset(a_rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .stall_cnt(a_cnt)
  );
  id_ex_pipe_stage #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(b_rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .stall_cnt(b_cnt)
  );
  id_ex_pipe_stage #(.DATA_W(8), .SKID(1), .CNT_W(3)) u_c (
    .clk(clk), .reset(c_rst), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_id), .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_od), .stall_cnt(c_cnt)
  );

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_od;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t ta[$];
  vec_t tb[$];
  logic [164:0] sbq[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t v(logic rst, logic fl, logic iv, logic [31:0] id, logic ordy,
                             logic e_ir, logic e_ov, logic [31:0] e_od, logic [15:0] e_cnt);
    vec_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.id = id; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic stream_cycle(input logic iv, input logic ordy);
    logic [164:0] d;
    logic [164:0] e;
    @(negedge clk);
    d = {133'b0, $urandom()};
    a_iv = iv; a_id = d; a_ordy = ordy; a_fl = 1'b0; a_rst = 1'b0;
    #1;
    chk("stream.ov", {191'b0, a_ov}, {191'b0, sbq.size() != 0});
    chk("stream.ir", {191'b0, a_ir}, {191'b0, sbq.size() < 2});
    if (a_ov && a_ordy) begin
      if (sbq.size() == 0) begin
        chk("stream.underflow", 192'd1, 192'd0);
      end else begin
        e = sbq.pop_front();
        chk("stream.od", {27'b0, a_od}, {27'b0, e});
      end
    end
    if (a_iv && a_ir) sbq.push_back(d);
  endtask

  initial begin
    // SKID=1 sequence: stream, skid fill/drain, flush in TWO, flush with offer, reset mid-transfer
    ta.push_back(v(0,0,1,32'h1,1, 1,0,32'h0,0));
    ta.push_back(v(0,0,1,32'h2,1, 1,1,32'h1,0));
    ta.push_back(v(0,0,1,32'h3,1, 1,1,32'h2,0));
    ta.push_back(v(0,0,1,32'h4,1, 1,1,32'h3,0));
    ta.push_back(v(0,0,1,32'h5,1, 1,1,32'h4,0));
    ta.push_back(v(0,0,0,32'h0,1, 1,1,32'h5,0));
    ta.push_back(v(0,0,1,32'hA,1, 1,0,32'h0,0));
    ta.push_back(v(0,0,1,32'hB,0, 1,1,32'hA,0));
    ta.push_back(v(0,0,1,32'hC,0, 0,1,32'hA,1));
    ta.push_back(v(0,0,1,32'hC,0, 0,1,32'hA,2));
    ta.push_back(v(0,0,1,32'hC,1, 0,1,32'hA,3));
    ta.push_back(v(0,0,1,32'hC,1, 1,1,32'hB,3));
    ta.push_back(v(0,0,0,32'h0,1, 1,1,32'hC,3));
    ta.push_back(v(0,0,0,32'h0,0, 1,0,32'h0,3));
    ta.push_back(v(0,0,1,32'h11,0, 1,0,32'h0,3));
    ta.push_back(v(0,0,1,32'h12,0, 1,1,32'h11,3));
    ta.push_back(v(0,1,1,32'hD,0, 0,1,32'h11,4));
    ta.push_back(v(0,0,0,32'h0,1, 1,0,32'h0,4));
    ta.push_back(v(0,1,1,32'hE,1, 1,0,32'h0,4));
    ta.push_back(v(0,0,1,32'h21,1, 1,0,32'h0,4));
    ta.push_back(v(1,0,1,32'h22,1, 1,1,32'h21,4));
    ta.push_back(v(0,0,0,32'h0,1, 1,0,32'h0,0));
    ta.push_back(v(0,0,0,32'h0,0, 1,0,32'h0,0));
    // SKID=0 sequence: combinational ready, back-to-back advance, flush discards offer
    tb.push_back(v(0,0,1,32'h31,0, 1,0,32'h0,0));
    tb.push_back(v(0,0,1,32'h32,0, 0,1,32'h31,0));
    tb.push_back(v(0,0,1,32'h32,1, 1,1,32'h31,1));
    tb.push_back(v(0,0,1,32'h33,1, 1,1,32'h32,1));
    tb.push_back(v(0,0,0,32'h0,1, 1,1,32'h33,1));
    tb.push_back(v(0,0,0,32'h0,0, 1,0,32'h0,1));
    tb.push_back(v(0,0,1,32'h34,0, 1,0,32'h0,1));
    tb.push_back(v(0,0,0,32'h0,0, 1,0,32'h0,1));
    tb[6].fl = 1'b1;

    @(negedge clk);
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    #1;
    chk("rst.a_ov", {191'b0, a_ov}, 192'd0);
    chk("rst.a_od", {27'b0, a_od}, 192'd0);
    chk("rst.a_cnt", {176'b0, a_cnt}, 192'd0);
    chk("rst.a_ir", {191'b0, a_ir}, 192'd1);
    chk("rst.b_ir", {191'b0, b_ir}, 192'd1);
    chk("rst.b_ov", {191'b0, b_ov}, 192'd0);

    foreach (ta[i]) begin
      if (i != 0) @(negedge clk);
      a_rst = ta[i].rst; a_fl = ta[i].fl; a_iv = ta[i].iv;
      a_id = {133'b0, ta[i].id}; a_ordy = ta[i].ordy;
      #1;
      chk($sformatf("A[%0d].ir", i), {191'b0, a_ir}, {191'b0, ta[i].e_ir});
      chk($sformatf("A[%0d].ov", i), {191'b0, a_ov}, {191'b0, ta[i].e_ov});
      chk($sformatf("A[%0d].od", i), {27'b0, a_od}, {160'b0, ta[i].e_od});
      chk($sformatf("A[%0d].cnt", i), {176'b0, a_cnt}, {176'b0, ta[i].e_cnt});
    end

    foreach (tb[i]) begin
      @(negedge clk);
      b_rst = tb[i].rst; b_fl = tb[i].fl; b_iv = tb[i].iv;
      b_id = tb[i].id; b_ordy = tb[i].ordy;
      #1;
      chk($sformatf("B[%0d].ir", i), {191'b0, b_ir}, {191'b0, tb[i].e_ir});
      chk($sformatf("B[%0d].ov", i), {191'b0, b_ov}, {191'b0, tb[i].e_ov});
      chk($sformatf("B[%0d].od", i), {160'b0, b_od}, {160'b0, tb[i].e_od});
      chk($sformatf("B[%0d].cnt", i), {176'b0, b_cnt}, {176'b0, tb[i].e_cnt});
    end

    // Randomised stream on the skid instance against a FIFO scoreboard
    for (int k = 0; k < 300; k++) begin
      stream_cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 4; k++) stream_cycle(1'b0, 1'b1);
    chk("stream.drained", {160'b0, 32'(sbq.size())}, 192'd0);

    // Narrow counter saturation, flush keeps it, reset clears it
    @(negedge clk);
    c_iv = 1'b1; c_id = 8'h5; c_ordy = 1'b0;
    @(negedge clk);
    c_iv = 1'b0; c_id = 8'h0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    #1;
    chk("C.cnt_sat", {189'b0, c_cnt}, 192'd7);
    chk("C.ov", {191'b0, c_ov}, 192'd1);
    chk("C.od", {184'b0, c_od}, 192'h5);
    @(negedge clk);
    c_fl = 1'b1;
    @(negedge clk);
    c_fl = 1'b0;
    #1;
    chk("C.cnt_after_flush", {189'b0, c_cnt}, 192'd7);
    chk("C.ov_after_flush", {191'b0, c_ov}, 192'd0);
    @(negedge clk);
    c_rst = 1'b1;
    @(negedge clk);
    c_rst = 1'b0;
    #1;
    chk("C.cnt_after_reset", {189'b0, c_cnt}, 192'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
